// File: rtl/cpu_pkg.sv
// Shared opcode map, flag struct and instruction field layout for cpu_core.
// Setting the MUL_EN macro makes opcode 001101 (MUL) an ALU operation.
package cpu_pkg;

   localparam int DATA_W      = 16;
   localparam int DEST_MSB    = 11;
   localparam int DEST_LSB    = 8;
   localparam int LOAD_LEN_W  = 8;
   localparam int STORE_LEN_W = 6;

   localparam logic [5:0] OP_NOP   = 6'b000000;
   localparam logic [5:0] OP_ADD   = 6'b000001;
   localparam logic [5:0] OP_SUB   = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b000011;
   localparam logic [5:0] OP_OR    = 6'b000100;
   localparam logic [5:0] OP_XOR   = 6'b000101;
   localparam logic [5:0] OP_NOT   = 6'b000110;
   localparam logic [5:0] OP_LSL   = 6'b000111;
   localparam logic [5:0] OP_LSR   = 6'b001000;
   localparam logic [5:0] OP_CMP   = 6'b001001;
   localparam logic [5:0] OP_MOV   = 6'b001010;
   localparam logic [5:0] OP_INC   = 6'b001011;
   localparam logic [5:0] OP_DEC   = 6'b001100;
   localparam logic [5:0] OP_MUL   = 6'b001101;
   localparam logic [5:0] OP_LOAD  = 6'b010000;
   localparam logic [5:0] OP_STORE = 6'b010001;
   localparam logic [5:0] OP_PUSH  = 6'b010010;
   localparam logic [5:0] OP_POP   = 6'b010011;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } flags_t;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_POP_PEND = 1'b1
   } stack_state_e;

   function automatic logic is_alu_op(input logic [5:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL,
         OP_LSR, OP_CMP, OP_MOV, OP_INC, OP_DEC: r = 1'b1;
`ifdef MUL_EN
         OP_MUL:                                 r = 1'b1;
`endif
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result and zero/negative/carry/overflow flags for ACC op imm.
// The MUL path exists only when MUL_EN is defined.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [5:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output flags_t            flags
);

   logic [DATA_W-1:0] w_opb;
   logic [DATA_W-1:0] w_res;
   logic [DATA_W:0]   w_wide;
   logic              w_carry;
   logic              w_ovf;
`ifdef MUL_EN
   logic [2*DATA_W-1:0] w_prod;
`endif

   // INC/DEC reuse the adder/subtractor with a constant one operand
   always_comb begin
      w_opb = b;
      if ((op == OP_INC) || (op == OP_DEC)) begin
         w_opb = 16'h0001;
      end else begin
         w_opb = b;
      end
   end

   // Operation select with per-family carry/overflow rules
   always_comb begin
      w_res   = 16'h0000;
      w_wide  = 17'h00000;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
`ifdef MUL_EN
      w_prod  = 32'h0000_0000;
`endif
      case (op)
         OP_ADD, OP_INC: begin
            w_wide  = {1'b0, a} + {1'b0, w_opb};
            w_res   = w_wide[DATA_W-1:0];
            w_carry = w_wide[DATA_W];
            w_ovf   = (a[15] == w_opb[15]) && (w_res[15] != a[15]);
         end
         OP_SUB, OP_CMP, OP_DEC: begin
            w_res   = a - w_opb;
            w_carry = (a < w_opb);
            w_ovf   = (a[15] != w_opb[15]) && (w_res[15] != a[15]);
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_NOT: w_res = ~a;
         OP_MOV: w_res = b;
         // Spare bit above/below the word catches the last bit shifted out
         OP_LSL: begin
            w_wide  = {1'b0, a} << b[3:0];
            w_res   = w_wide[DATA_W-1:0];
            w_carry = w_wide[DATA_W];
         end
         OP_LSR: begin
            w_wide  = {a, 1'b0} >> b[3:0];
            w_res   = w_wide[DATA_W:1];
            w_carry = w_wide[0];
         end
`ifdef MUL_EN
         OP_MUL: begin
            w_prod  = {16'h0000, a} * {16'h0000, b};
            w_res   = w_prod[DATA_W-1:0];
            w_carry = |w_prod[2*DATA_W-1:DATA_W];
         end
`endif
         default: begin
            w_res   = 16'h0000;
            w_carry = 1'b0;
            w_ovf   = 1'b0;
         end
      endcase
   end

   assign result         = w_res;
   assign flags.zero     = (w_res == 16'h0000);
   assign flags.negative = w_res[DATA_W-1];
   assign flags.carry    = w_carry;
   assign flags.overflow = w_ovf;

endmodule

// File: rtl/cpu_core.sv
// Execute/control core: accumulator, stack pointer, flags and registered strobes.
// Define MUL_EN to enable the MUL opcode (001101); otherwise it executes as NOP.
module cpu_core
   import cpu_pkg::*;
#(
   parameter logic [15:0] STACK_TOP  = 16'hFFFF,
   parameter logic [15:0] STACK_BASE = 16'hFF00
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] imm,
   input  logic [15:0] instr,
   input  logic [5:0]  opcode,
   output logic [7:0]  readLen,
   output logic        reg_write_en,
   output logic [3:0]  reg_dest,
   output logic [5:0]  writeData,
   output logic        writeEnable,
   output logic        push,
   output logic        pop,
   output logic        pop_done,
   output logic [15:0] dafa_in,
   output logic [15:0] address,
   output logic        alu_done,
   output logic [15:0] alu_out,
   output logic        zero,
   output logic        negative,
   output logic        carry,
   output logic        overflow
);

   logic [15:0]  r_acc;
   logic [15:0]  r_sp;
   flags_t       r_flags;
   stack_state_e r_state;
   stack_state_e w_state_nxt;

   logic [15:0] w_alu_res;
   flags_t      w_alu_flags;
   logic        w_push_ok;
   logic        w_pop_ok;

   logic [15:0] w_acc_nxt;
   logic [15:0] w_sp_nxt;
   flags_t      w_flags_nxt;
   logic [7:0]  w_read_len_nxt;
   logic        w_rwe_nxt;
   logic [3:0]  w_dest_nxt;
   logic [5:0]  w_wdata_nxt;
   logic        w_we_nxt;
   logic        w_push_nxt;
   logic        w_pop_nxt;
   logic        w_pop_done_nxt;
   logic [15:0] w_dafa_nxt;
   logic [15:0] w_addr_nxt;
   logic        w_alu_done_nxt;
   logic [15:0] w_alu_out_nxt;

   cpu_alu u_alu (
      .op     (opcode),
      .a      (r_acc),
      .b      (imm),
      .result (w_alu_res),
      .flags  (w_alu_flags)
   );

   assign w_push_ok = (r_sp != STACK_BASE);
   assign w_pop_ok  = (r_sp != STACK_TOP);

   // Stack FSM state register: remembers that a pop completes next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Stack FSM next state
   always_comb begin
      w_state_nxt = ST_IDLE;
      if ((opcode == OP_POP) && w_pop_ok) begin
         w_state_nxt = ST_POP_PEND;
      end else begin
         w_state_nxt = ST_IDLE;
      end
   end

   // Stack FSM output: completion pulse independent of the following opcode
   always_comb begin
      case (r_state)
         ST_POP_PEND: w_pop_done_nxt = 1'b1;
         ST_IDLE:     w_pop_done_nxt = 1'b0;
         default:     w_pop_done_nxt = 1'b0;
      endcase
   end

   // Instruction decode into next architectural state and next output values
   always_comb begin
      w_acc_nxt      = r_acc;
      w_sp_nxt       = r_sp;
      w_flags_nxt    = r_flags;
      w_read_len_nxt = 8'h00;
      w_rwe_nxt      = 1'b0;
      w_dest_nxt     = reg_dest;
      w_wdata_nxt    = 6'h00;
      w_we_nxt       = 1'b0;
      w_push_nxt     = 1'b0;
      w_pop_nxt      = 1'b0;
      w_dafa_nxt     = dafa_in;
      w_addr_nxt     = address;
      w_alu_done_nxt = 1'b0;
      w_alu_out_nxt  = alu_out;
      if (is_alu_op(opcode)) begin
         w_flags_nxt    = w_alu_flags;
         w_alu_out_nxt  = w_alu_res;
         w_alu_done_nxt = 1'b1;
         // CMP only updates flags and alu_out
         if (opcode != OP_CMP) begin
            w_acc_nxt  = w_alu_res;
            w_rwe_nxt  = 1'b1;
            w_dest_nxt = instr[DEST_MSB:DEST_LSB];
         end else begin
            w_acc_nxt  = r_acc;
         end
      end else begin
         case (opcode)
            OP_LOAD: begin
               w_addr_nxt     = imm;
               w_read_len_nxt = instr[LOAD_LEN_W-1:0];
               w_rwe_nxt      = 1'b1;
               w_dest_nxt     = instr[DEST_MSB:DEST_LSB];
            end
            OP_STORE: begin
               w_addr_nxt  = imm;
               w_dafa_nxt  = r_acc;
               w_wdata_nxt = instr[STORE_LEN_W-1:0];
               w_we_nxt    = 1'b1;
            end
            OP_PUSH: begin
               if (w_push_ok) begin
                  w_sp_nxt    = r_sp - 16'h0001;
                  w_addr_nxt  = r_sp - 16'h0001;
                  w_dafa_nxt  = r_acc;
                  w_wdata_nxt = 6'd2;
                  w_we_nxt    = 1'b1;
                  w_push_nxt  = 1'b1;
               end else begin
                  w_sp_nxt    = r_sp;
               end
            end
            OP_POP: begin
               if (w_pop_ok) begin
                  w_sp_nxt       = r_sp + 16'h0001;
                  w_addr_nxt     = r_sp;
                  w_read_len_nxt = 8'd2;
                  w_pop_nxt      = 1'b1;
               end else begin
                  w_sp_nxt       = r_sp;
               end
            end
            default: begin
               w_acc_nxt = r_acc;
            end
         endcase
      end
   end

   // Architectural registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= 16'h0000;
         r_sp         <= STACK_TOP;
         r_flags      <= '0;
         readLen      <= 8'h00;
         reg_write_en <= 1'b0;
         reg_dest     <= 4'h0;
         writeData    <= 6'h00;
         writeEnable  <= 1'b0;
         push         <= 1'b0;
         pop          <= 1'b0;
         pop_done     <= 1'b0;
         dafa_in      <= 16'h0000;
         address      <= 16'h0000;
         alu_done     <= 1'b0;
         alu_out      <= 16'h0000;
      end else begin
         r_acc        <= w_acc_nxt;
         r_sp         <= w_sp_nxt;
         r_flags      <= w_flags_nxt;
         readLen      <= w_read_len_nxt;
         reg_write_en <= w_rwe_nxt;
         reg_dest     <= w_dest_nxt;
         writeData    <= w_wdata_nxt;
         writeEnable  <= w_we_nxt;
         push         <= w_push_nxt;
         pop          <= w_pop_nxt;
         pop_done     <= w_pop_done_nxt;
         dafa_in      <= w_dafa_nxt;
         address      <= w_addr_nxt;
         alu_done     <= w_alu_done_nxt;
         alu_out      <= w_alu_out_nxt;
      end
   end

   assign zero     = r_flags.zero;
   assign negative = r_flags.negative;
   assign carry    = r_flags.carry;
   assign overflow = r_flags.overflow;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed scenarios with literal expectations
// plus randomized instruction streams checked against a behavioural model.
module tb_cpu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imm;
   logic [15:0] instr;
   logic [5:0]  opcode;
   logic [7:0]  readLen;
   logic        reg_write_en;
   logic [3:0]  reg_dest;
   logic [5:0]  writeData;
   logic        writeEnable;
   logic        push;
   logic        pop;
   logic        pop_done;
   logic [15:0] dafa_in;
   logic [15:0] address;
   logic        alu_done;
   logic [15:0] alu_out;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   cpu_core dut (
      .clk          (clk),
      .rst          (rst),
      .imm          (imm),
      .instr        (instr),
      .opcode       (opcode),
      .readLen      (readLen),
      .reg_write_en (reg_write_en),
      .reg_dest     (reg_dest),
      .writeData    (writeData),
      .writeEnable  (writeEnable),
      .push         (push),
      .pop          (pop),
      .pop_done     (pop_done),
      .dafa_in      (dafa_in),
      .address      (address),
      .alu_done     (alu_done),
      .alu_out      (alu_out),
      .zero         (zero),
      .negative     (negative),
      .carry        (carry),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int s16(input logic [15:0] x);
      return int'($signed(x));
   endfunction

   // Behavioural model state and expected outputs
   logic [15:0] m_acc, m_sp;
   logic        m_pend;
   logic        m_valid = 1'b0;
   logic        m_z, m_n, m_c, m_v;
   logic [7:0]  e_rlen;
   logic [5:0]  e_wdata;
   logic        e_rwe, e_we, e_push, e_pop, e_pdone, e_adone, e_rst;
   logic [3:0]  e_dest;
   logic [15:0] e_dafa, e_addr, e_aout;

   always @(posedge clk) begin : model
      logic [15:0] b, res;
      logic [31:0] u;
      logic        alu, c, v;
      int          n, sr;
      e_pdone = m_pend;
      m_pend  = 1'b0;
      e_rlen = 8'h00; e_wdata = 6'h00;
      e_rwe = 1'b0; e_we = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_adone = 1'b0;
      e_rst = rst;
      alu = 1'b0; c = 1'b0; v = 1'b0; res = 16'h0000;
      n = int'(imm[3:0]);
      if (rst) begin
         e_pdone = 1'b0;
         m_acc = 16'h0000; m_sp = 16'hFFFF;
         {m_z, m_n, m_c, m_v} = 4'b0000;
         e_dest = 4'h0; e_dafa = 16'h0000; e_addr = 16'h0000; e_aout = 16'h0000;
      end else begin
         case (opcode)
            6'd1, 6'd11: begin
               b = (opcode == 6'd11) ? 16'h0001 : imm;
               u = 32'(m_acc) + 32'(b);
               res = u[15:0];
               c = (u > 32'h0000FFFF);
               sr = s16(m_acc) + s16(b);
               v = (sr > 32767) || (sr < -32768);
               alu = 1'b1;
            end
            6'd2, 6'd9, 6'd12: begin
               b = (opcode == 6'd12) ? 16'h0001 : imm;
               res = m_acc - b;
               c = (m_acc < b);
               sr = s16(m_acc) - s16(b);
               v = (sr > 32767) || (sr < -32768);
               alu = 1'b1;
            end
            6'd3: begin res = m_acc & imm; alu = 1'b1; end
            6'd4: begin res = m_acc | imm; alu = 1'b1; end
            6'd5: begin res = m_acc ^ imm; alu = 1'b1; end
            6'd6: begin res = ~m_acc; alu = 1'b1; end
            6'd7: begin
               res = m_acc << n;
               c = (n == 0) ? 1'b0 : m_acc[16-n];
               alu = 1'b1;
            end
            6'd8: begin
               res = m_acc >> n;
               c = (n == 0) ? 1'b0 : m_acc[n-1];
               alu = 1'b1;
            end
            6'd10: begin res = imm; alu = 1'b1; end
`ifdef MUL_EN
            6'd13: begin
               u = 32'(m_acc) * 32'(imm);
               res = u[15:0];
               c = (u[31:16] != 16'h0000);
               alu = 1'b1;
            end
`endif
            6'd16: begin
               e_addr = imm; e_rlen = instr[7:0]; e_rwe = 1'b1; e_dest = instr[11:8];
            end
            6'd17: begin
               e_addr = imm; e_dafa = m_acc; e_wdata = instr[5:0]; e_we = 1'b1;
            end
            6'd18: if (m_sp != 16'hFF00) begin
               m_sp = m_sp - 16'h0001;
               e_addr = m_sp; e_dafa = m_acc; e_wdata = 6'd2; e_we = 1'b1; e_push = 1'b1;
            end
            6'd19: if (m_sp != 16'hFFFF) begin
               e_addr = m_sp; e_rlen = 8'd2; e_pop = 1'b1;
               m_sp = m_sp + 16'h0001;
               m_pend = 1'b1;
            end
            default: ;
         endcase
         if (alu) begin
            m_z = (res == 16'h0000); m_n = res[15]; m_c = c; m_v = v;
            e_aout = res; e_adone = 1'b1;
            if (opcode != 6'd9) begin
               m_acc = res; e_rwe = 1'b1; e_dest = instr[11:8];
            end
         end
      end
      m_valid = 1'b1;
   end

   // Single compare process against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("readLen", readLen, e_rlen);
         chk("writeData", writeData, e_wdata);
         chk("reg_write_en", reg_write_en, e_rwe);
         chk("writeEnable", writeEnable, e_we);
         chk("push", push, e_push);
         chk("pop", pop, e_pop);
         chk("pop_done", pop_done, e_pdone);
         chk("alu_done", alu_done, e_adone);
         chk("flags", {zero, negative, carry, overflow}, {m_z, m_n, m_c, m_v});
         if (e_adone || e_rst) chk("alu_out", alu_out, e_aout);
         if (e_rwe || e_rst) chk("reg_dest", reg_dest, e_dest);
         if (e_we || e_rlen != 8'h00 || e_pop || e_rst) chk("address", address, e_addr);
         if (e_we || e_rst) chk("dafa_in", dafa_in, e_dafa);
      end
   end

   task automatic step(input logic r, input logic [5:0] op, input logic [15:0] i, input logic [15:0] ins);
      rst = r; opcode = op; imm = i; instr = ins;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      step(1'b1, 6'd0, 16'h0000, 16'h0000);
      step(1'b1, 6'd10, 16'hBEEF, 16'h0F00);
      chk("rst_all_zero", {readLen, reg_write_en, reg_dest, writeData, writeEnable, push, pop,
                           pop_done, alu_done, zero, negative, carry, overflow}, 32'h0);
      chk("rst_buses", {address, dafa_in} | {alu_out, 16'h0000}, 32'h0);

      step(1'b0, 6'd10, 16'h1234, 16'h0100);
      chk("mov_out", alu_out, 32'h1234);
      chk("mov_rwe_dest", {reg_write_en, reg_dest, zero, alu_done}, {1'b1, 4'h1, 1'b0, 1'b1});

      step(1'b0, 6'd10, 16'hFFFF, 16'h0200);
      step(1'b0, 6'd1, 16'h0001, 16'h0200);
      chk("add_wrap", {alu_out, zero, carry, overflow}, {16'h0000, 1'b1, 1'b1, 1'b0});
      step(1'b0, 6'd10, 16'h7FFF, 16'h0200);
      step(1'b0, 6'd1, 16'h0001, 16'h0200);
      chk("add_ovf", {alu_out, negative, overflow}, {16'h8000, 1'b1, 1'b1});

      step(1'b0, 6'd10, 16'h1234, 16'h0000);
      step(1'b0, 6'd18, 16'h0000, 16'h0000);
      chk("push1", {push, writeEnable, writeData, address, dafa_in}, {1'b1, 1'b1, 6'd2, 16'hFFFE, 16'h1234});
      step(1'b0, 6'd18, 16'h0000, 16'h0000);
      chk("push2", {push, address}, {1'b1, 16'hFFFD});

      step(1'b0, 6'd19, 16'h0000, 16'h0000);
      chk("pop1", {pop, address, readLen}, {1'b1, 16'hFFFD, 8'd2});
      step(1'b0, 6'd19, 16'h0000, 16'h0000);
      chk("pop2", {pop, pop_done, address}, {1'b1, 1'b1, 16'hFFFE});
      step(1'b0, 6'd19, 16'h0000, 16'h0000);
      chk("pop_empty", {pop, pop_done, readLen}, {1'b0, 1'b1, 8'd0});
      step(1'b0, 6'd0, 16'h0000, 16'h0000);
      chk("pop_empty_done", pop_done, 32'h0);

      for (int i = 0; i < 255; i++) step(1'b0, 6'd18, 16'h0000, 16'h0000);
      chk("push_last", {push, address}, {1'b1, 16'hFF00});
      step(1'b0, 6'd18, 16'h0000, 16'h0000);
      chk("push_full", {push, writeEnable, writeData}, 32'h0);
      step(1'b0, 6'd19, 16'h0000, 16'h0000);
      chk("pop_after_full", {pop, address}, {1'b1, 16'hFF00});

      step(1'b0, 6'd10, 16'h0005, 16'h0000);
      step(1'b0, 6'd9, 16'h0007, 16'h0300);
      chk("cmp", {alu_out, carry, negative, zero, reg_write_en}, {16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0});
      step(1'b0, 6'd17, 16'h0040, 16'h003F);
      chk("cmp_acc_kept", {dafa_in, writeData, address}, {16'h0005, 6'h3F, 16'h0040});

      step(1'b0, 6'd19, 16'h0000, 16'h0000);
      chk("pop_before_rst", pop, 32'h1);
      step(1'b1, 6'd19, 16'h0000, 16'h0000);
      chk("rst_kills_done", {pop_done, pop, alu_out, address}, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
         else if ($urandom_range(0, 2) == 0) op = 6'($urandom_range(18, 19));
         else op = 6'($urandom_range(0, 19));
         step(($urandom_range(0, 127) == 0), op, 16'($urandom), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
